// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and
// saturating stall/flush event counters.
module id_ex_pipe #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [31:0]       id_instr,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_ALU_src,
    input  logic              id_WB_data_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [1:0]        id_ALU_op,
    input  logic              ex_branch_taken,
    output logic              ex_valid,
    output logic [PC_W-1:0]   ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              ex_ALU_src,
    output logic              ex_WB_data_src,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [1:0]        ex_ALU_op,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic [2:0] id_funct3;
    logic [6:0] id_funct7;
    logic       rs1_used;
    logic       rs2_used;
    logic       hazard;
    logic       capture;

    logic              ex_valid_q, ex_valid_d;
    logic [PC_W-1:0]   ex_pc_q, ex_pc_d;
    logic [DATA_W-1:0] ex_rd1_q, ex_rd1_d;
    logic [DATA_W-1:0] ex_rd2_q, ex_rd2_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [4:0]        ex_rs1_q, ex_rs1_d;
    logic [4:0]        ex_rs2_q, ex_rs2_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic [2:0]        ex_funct3_q, ex_funct3_d;
    logic [6:0]        ex_funct7_q, ex_funct7_d;
    logic              ex_ALU_src_q, ex_ALU_src_d;
    logic              ex_WB_data_src_q, ex_WB_data_src_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic              ex_mem_read_q, ex_mem_read_d;
    logic              ex_mem_write_q, ex_mem_write_d;
    logic [1:0]        ex_ALU_op_q, ex_ALU_op_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    always_comb begin
        id_opcode = id_instr[6:0];
        id_rd     = id_instr[11:7];
        id_funct3 = id_instr[14:12];
        id_rs1    = id_instr[19:15];
        id_rs2    = id_instr[24:20];
        id_funct7 = id_instr[31:25];
    end

    // Only opcodes that actually read a source register can create a load-use hazard.
    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (id_opcode)
            OPC_OP:     begin rs1_used = 1'b1; rs2_used = 1'b1; end
            OPC_STORE:  begin rs1_used = 1'b1; rs2_used = 1'b1; end
            OPC_BRANCH: begin rs1_used = 1'b1; rs2_used = 1'b1; end
            OPC_OP_IMM: rs1_used = 1'b1;
            OPC_LOAD:   rs1_used = 1'b1;
            OPC_JALR:   rs1_used = 1'b1;
            default: begin
                rs1_used = 1'b0;
                rs2_used = 1'b0;
            end
        endcase
    end

    always_comb begin
        hazard = ex_valid_q && ex_mem_read_q && id_valid && (ex_rd_q != 5'd0) &&
                 (((ex_rd_q == id_rs1) && rs1_used) || ((ex_rd_q == id_rs2) && rs2_used));
        stall   = hazard && !ex_branch_taken;
        capture = !ex_branch_taken && !stall && id_valid;
    end

    // Every non-capture case (flush, stall, empty decode) loads an all-zero bubble.
    always_comb begin
        ex_valid_d       = 1'b0;
        ex_pc_d          = '0;
        ex_rd1_d         = '0;
        ex_rd2_d         = '0;
        ex_imm_d         = '0;
        ex_rs1_d         = 5'd0;
        ex_rs2_d         = 5'd0;
        ex_rd_d          = 5'd0;
        ex_funct3_d      = 3'd0;
        ex_funct7_d      = 7'd0;
        ex_ALU_src_d     = 1'b0;
        ex_WB_data_src_d = 1'b0;
        ex_reg_write_d   = 1'b0;
        ex_mem_read_d    = 1'b0;
        ex_mem_write_d   = 1'b0;
        ex_ALU_op_d      = 2'd0;
        if (capture) begin
            ex_valid_d       = 1'b1;
            ex_pc_d          = id_pc;
            ex_rd1_d         = id_rd1;
            ex_rd2_d         = id_rd2;
            ex_imm_d         = id_imm;
            ex_rs1_d         = id_rs1;
            ex_rs2_d         = id_rs2;
            ex_rd_d          = id_rd;
            ex_funct3_d      = id_funct3;
            ex_funct7_d      = id_funct7;
            ex_ALU_src_d     = id_ALU_src;
            ex_WB_data_src_d = id_WB_data_src;
            ex_reg_write_d   = id_reg_write;
            ex_mem_read_d    = id_mem_read;
            ex_mem_write_d   = id_mem_write;
            ex_ALU_op_d      = id_ALU_op;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
        if (ex_branch_taken && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q       <= 1'b0;
            ex_pc_q          <= '0;
            ex_rd1_q         <= '0;
            ex_rd2_q         <= '0;
            ex_imm_q         <= '0;
            ex_rs1_q         <= 5'd0;
            ex_rs2_q         <= 5'd0;
            ex_rd_q          <= 5'd0;
            ex_funct3_q      <= 3'd0;
            ex_funct7_q      <= 7'd0;
            ex_ALU_src_q     <= 1'b0;
            ex_WB_data_src_q <= 1'b0;
            ex_reg_write_q   <= 1'b0;
            ex_mem_read_q    <= 1'b0;
            ex_mem_write_q   <= 1'b0;
            ex_ALU_op_q      <= 2'd0;
            stall_count_q    <= '0;
            flush_count_q    <= '0;
        end else begin
            ex_valid_q       <= ex_valid_d;
            ex_pc_q          <= ex_pc_d;
            ex_rd1_q         <= ex_rd1_d;
            ex_rd2_q         <= ex_rd2_d;
            ex_imm_q         <= ex_imm_d;
            ex_rs1_q         <= ex_rs1_d;
            ex_rs2_q         <= ex_rs2_d;
            ex_rd_q          <= ex_rd_d;
            ex_funct3_q      <= ex_funct3_d;
            ex_funct7_q      <= ex_funct7_d;
            ex_ALU_src_q     <= ex_ALU_src_d;
            ex_WB_data_src_q <= ex_WB_data_src_d;
            ex_reg_write_q   <= ex_reg_write_d;
            ex_mem_read_q    <= ex_mem_read_d;
            ex_mem_write_q   <= ex_mem_write_d;
            ex_ALU_op_q      <= ex_ALU_op_d;
            stall_count_q    <= stall_count_d;
            flush_count_q    <= flush_count_d;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_pc          = ex_pc_q;
    assign ex_rd1         = ex_rd1_q;
    assign ex_rd2         = ex_rd2_q;
    assign ex_imm         = ex_imm_q;
    assign ex_rs1         = ex_rs1_q;
    assign ex_rs2         = ex_rs2_q;
    assign ex_rd          = ex_rd_q;
    assign ex_funct3      = ex_funct3_q;
    assign ex_funct7      = ex_funct7_q;
    assign ex_ALU_src     = ex_ALU_src_q;
    assign ex_WB_data_src = ex_WB_data_src_q;
    assign ex_reg_write   = ex_reg_write_q;
    assign ex_mem_read    = ex_mem_read_q;
    assign ex_mem_write   = ex_mem_write_q;
    assign ex_ALU_op      = ex_ALU_op_q;
    assign stall_count    = stall_count_q;
    assign flush_count    = flush_count_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed table-driven bench for id_ex_pipe, plus hand sequences for
// reset-during-stall and counter saturation (second instance with CNT_W=2).
module tb_id_ex_pipe;

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [8:0]  pc;
        logic [4:0]  ctrl;
        logic [1:0]  aluop;
        logic        br;
        logic        e_stall;
        logic        e_valid;
        logic [4:0]  e_rd;
        logic [4:0]  e_rs1;
        logic [4:0]  e_rs2;
        logic [2:0]  e_f3;
        logic [6:0]  e_f7;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_imm;
        logic [8:0]  e_pc;
        logic [4:0]  e_ctrl;
        logic [1:0]  e_aluop;
        logic [15:0] e_scnt;
        logic [15:0] e_fcnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [8:0]  id_pc;
    logic [31:0] id_instr;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic        id_ALU_src, id_WB_data_src, id_reg_write, id_mem_read, id_mem_write;
    logic [1:0]  id_ALU_op;
    logic        ex_branch_taken;

    logic        ex_valid;
    logic [8:0]  ex_pc;
    logic [31:0] ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_ALU_src, ex_WB_data_src, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [1:0]  ex_ALU_op;
    logic        stall;
    logic [15:0] stall_count, flush_count;

    logic        s_ex_valid;
    logic [8:0]  s_ex_pc;
    logic [31:0] s_ex_rd1, s_ex_rd2, s_ex_imm;
    logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic [2:0]  s_ex_funct3;
    logic [6:0]  s_ex_funct7;
    logic        s_ex_ALU_src, s_ex_WB_data_src, s_ex_reg_write, s_ex_mem_read, s_ex_mem_write;
    logic [1:0]  s_ex_ALU_op;
    logic        s_stall;
    logic [1:0]  s_stall_count, s_flush_count;

    int applied = 0;
    int miscompares = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_ALU_src(id_ALU_src), .id_WB_data_src(id_WB_data_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_ALU_op(id_ALU_op),
        .ex_branch_taken(ex_branch_taken),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_ALU_src(ex_ALU_src), .ex_WB_data_src(ex_WB_data_src), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_ALU_op(ex_ALU_op),
        .stall(stall), .stall_count(stall_count), .flush_count(flush_count)
    );

    id_ex_pipe #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_ALU_src(id_ALU_src), .id_WB_data_src(id_WB_data_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_ALU_op(id_ALU_op),
        .ex_branch_taken(ex_branch_taken),
        .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rd1(s_ex_rd1), .ex_rd2(s_ex_rd2), .ex_imm(s_ex_imm),
        .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_funct3(s_ex_funct3), .ex_funct7(s_ex_funct7),
        .ex_ALU_src(s_ex_ALU_src), .ex_WB_data_src(s_ex_WB_data_src), .ex_reg_write(s_ex_reg_write),
        .ex_mem_read(s_ex_mem_read), .ex_mem_write(s_ex_mem_write), .ex_ALU_op(s_ex_ALU_op),
        .stall(s_stall), .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    // Captured-instruction vector: stall expectation before the edge, EX contents after it.
    function automatic vec_t mkCap(input logic [31:0] instr, input logic [31:0] rd1, input logic [31:0] rd2,
                                   input logic [31:0] imm, input logic [8:0] pc, input logic [4:0] ctrl,
                                   input logic [1:0] aluop, input logic [4:0] erd, input logic [4:0] ers1,
                                   input logic [4:0] ers2, input logic [2:0] ef3, input logic [6:0] ef7,
                                   input logic [15:0] scnt, input logic [15:0] fcnt);
        vec_t t;
        t.v = 1'b1; t.instr = instr; t.rd1 = rd1; t.rd2 = rd2; t.imm = imm; t.pc = pc;
        t.ctrl = ctrl; t.aluop = aluop; t.br = 1'b0; t.e_stall = 1'b0; t.e_valid = 1'b1;
        t.e_rd = erd; t.e_rs1 = ers1; t.e_rs2 = ers2; t.e_f3 = ef3; t.e_f7 = ef7;
        t.e_rd1 = rd1; t.e_rd2 = rd2; t.e_imm = imm; t.e_pc = pc; t.e_ctrl = ctrl; t.e_aluop = aluop;
        t.e_scnt = scnt; t.e_fcnt = fcnt;
        return t;
    endfunction

    // Bubble vector: everything in EX is expected to be zero after the edge.
    function automatic vec_t mkBub(input logic v, input logic [31:0] instr, input logic [31:0] rd1,
                                   input logic [31:0] rd2, input logic [8:0] pc, input logic [4:0] ctrl,
                                   input logic [1:0] aluop, input logic br, input logic est,
                                   input logic [15:0] scnt, input logic [15:0] fcnt);
        vec_t t;
        t.v = v; t.instr = instr; t.rd1 = rd1; t.rd2 = rd2; t.imm = 32'd0; t.pc = pc;
        t.ctrl = ctrl; t.aluop = aluop; t.br = br; t.e_stall = est; t.e_valid = 1'b0;
        t.e_rd = 5'd0; t.e_rs1 = 5'd0; t.e_rs2 = 5'd0; t.e_f3 = 3'd0; t.e_f7 = 7'd0;
        t.e_rd1 = 32'd0; t.e_rd2 = 32'd0; t.e_imm = 32'd0; t.e_pc = 9'd0; t.e_ctrl = 5'd0;
        t.e_aluop = 2'd0; t.e_scnt = scnt; t.e_fcnt = fcnt;
        return t;
    endfunction

    task automatic applyStimulus(input vec_t t);
        id_valid = t.v;
        id_instr = t.instr;
        id_rd1 = t.rd1;
        id_rd2 = t.rd2;
        id_imm = t.imm;
        id_pc = t.pc;
        {id_ALU_src, id_WB_data_src, id_reg_write, id_mem_read, id_mem_write} = t.ctrl;
        id_ALU_op = t.aluop;
        ex_branch_taken = t.br;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkEx(input vec_t t, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        checkOutput({p, ".ex_valid"}, 32'(ex_valid), 32'(t.e_valid));
        checkOutput({p, ".ex_rd"}, 32'(ex_rd), 32'(t.e_rd));
        checkOutput({p, ".ex_rs1"}, 32'(ex_rs1), 32'(t.e_rs1));
        checkOutput({p, ".ex_rs2"}, 32'(ex_rs2), 32'(t.e_rs2));
        checkOutput({p, ".ex_funct3"}, 32'(ex_funct3), 32'(t.e_f3));
        checkOutput({p, ".ex_funct7"}, 32'(ex_funct7), 32'(t.e_f7));
        checkOutput({p, ".ex_rd1"}, ex_rd1, t.e_rd1);
        checkOutput({p, ".ex_rd2"}, ex_rd2, t.e_rd2);
        checkOutput({p, ".ex_imm"}, ex_imm, t.e_imm);
        checkOutput({p, ".ex_pc"}, 32'(ex_pc), 32'(t.e_pc));
        checkOutput({p, ".ex_ctrl"},
                    32'({ex_ALU_src, ex_WB_data_src, ex_reg_write, ex_mem_read, ex_mem_write}),
                    32'(t.e_ctrl));
        checkOutput({p, ".ex_ALU_op"}, 32'(ex_ALU_op), 32'(t.e_aluop));
        checkOutput({p, ".stall_count"}, 32'(stall_count), 32'(t.e_scnt));
        checkOutput({p, ".flush_count"}, 32'(flush_count), 32'(t.e_fcnt));
    endtask

    initial begin
        vec_t idle;
        idle = mkBub(1'b0, 32'd0, 32'd0, 32'd0, 9'd0, 5'd0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0);

        // add x3,x1,x2 / lw x5,0(x1) / dependent add x6,x5,x2 (stall then capture)
        vecs.push_back(mkCap(32'h002081B3, 5, 7, 0, 9'd4, 5'b00100, 2'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 0, 0));
        vecs.push_back(mkCap(32'h0000A283, 100, 0, 0, 9'd8, 5'b11110, 2'd0, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 0, 0));
        vecs.push_back(mkBub(1'b1, 32'h00228333, 9, 7, 9'd12, 5'b00100, 2'd2, 1'b0, 1'b1, 1, 0));
        vecs.push_back(mkCap(32'h00228333, 9, 7, 0, 9'd12, 5'b00100, 2'd2, 5'd6, 5'd5, 5'd2, 3'd0, 7'd0, 1, 0));
        // lw x0 then use of x0: no stall
        vecs.push_back(mkCap(32'h0000A003, 11, 0, 0, 9'd16, 5'b11110, 2'd0, 5'd0, 5'd1, 5'd0, 3'd2, 7'd0, 1, 0));
        vecs.push_back(mkCap(32'h00200333, 0, 7, 0, 9'd20, 5'b00100, 2'd2, 5'd6, 5'd0, 5'd2, 3'd0, 7'd0, 1, 0));
        // lw x5 then addi x6,x7,5 (rs2 field = 5 but unused): no stall
        vecs.push_back(mkCap(32'h0000A283, 100, 0, 0, 9'd24, 5'b11110, 2'd0, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 1, 0));
        vecs.push_back(mkCap(32'h00538313, 3, 4, 5, 9'd28, 5'b10100, 2'd3, 5'd6, 5'd7, 5'd5, 3'd0, 7'd0, 1, 0));
        // empty decode slot
        vecs.push_back(mkBub(1'b0, 32'h002081B3, 1, 2, 9'd30, 5'b00100, 2'd2, 1'b0, 1'b0, 1, 0));
        // load in EX, dependent add in ID, flush same cycle: flush wins
        vecs.push_back(mkCap(32'h0000A283, 100, 0, 0, 9'd32, 5'b11110, 2'd0, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 1, 0));
        vecs.push_back(mkBub(1'b1, 32'h00228333, 9, 7, 9'd36, 5'b00100, 2'd2, 1'b1, 1'b0, 1, 1));
        vecs.push_back(mkBub(1'b1, 32'h002081B3, 5, 7, 9'd40, 5'b00100, 2'd2, 1'b1, 1'b0, 1, 2));
        // lw x5, lw x8, add x6,x5,x2: third instruction does not stall
        vecs.push_back(mkCap(32'h0000A283, 100, 0, 0, 9'd44, 5'b11110, 2'd0, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 1, 2));
        vecs.push_back(mkCap(32'h0000A403, 200, 0, 0, 9'd48, 5'b11110, 2'd0, 5'd8, 5'd1, 5'd0, 3'd2, 7'd0, 1, 2));
        vecs.push_back(mkCap(32'h00228333, 9, 7, 0, 9'd52, 5'b00100, 2'd2, 5'd6, 5'd5, 5'd2, 3'd0, 7'd0, 1, 2));
        // lw x5 then jalr x1,0(x5): rs1 hazard; then sub x3,x1,x2 checks funct7
        vecs.push_back(mkCap(32'h0000A283, 100, 0, 0, 9'd56, 5'b11110, 2'd0, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 1, 2));
        vecs.push_back(mkBub(1'b1, 32'h000280E7, 9, 0, 9'd60, 5'b10100, 2'd0, 1'b0, 1'b1, 2, 2));
        vecs.push_back(mkCap(32'h402081B3, 5, 7, 0, 9'd64, 5'b00100, 2'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 2, 2));

        // Reset for two cycles with random decode inputs
        @(negedge clk);
        reset = 1'b1;
        id_valid = 1'b1;
        id_instr = $urandom;
        id_rd1 = $urandom;
        id_rd2 = $urandom;
        id_imm = $urandom;
        id_pc = 9'($urandom);
        {id_ALU_src, id_WB_data_src, id_reg_write, id_mem_read, id_mem_write} = 5'($urandom);
        id_ALU_op = 2'($urandom);
        ex_branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.stall", 32'(stall), 32'd0);
        checkEx(idle, -1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d.stall", i), 32'(stall), 32'(vecs[i].e_stall));
            @(posedge clk);
            #1;
            checkEx(vecs[i], i);
            @(negedge clk);
        end

        // Reset asserted while a load-use stall is pending
        applyStimulus(mkCap(32'h0000A283, 100, 0, 0, 9'd68, 5'b11110, 2'd0, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        applyStimulus(mkCap(32'h00228333, 9, 7, 0, 9'd72, 5'b00100, 2'd2, 5'd6, 5'd5, 5'd2, 3'd0, 7'd0, 0, 0));
        reset = 1'b1;
        #1;
        checkOutput("rststall.stall_before", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        checkEx(idle, 100);
        checkOutput("rststall.stall_after", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Five consecutive flushes: CNT_W=2 instance saturates at 3
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(mkBub(1'b0, 32'd0, 0, 0, 9'd0, 5'd0, 2'd0, 1'b1, 1'b0, 0, 0));
            @(posedge clk);
            #1;
            checkOutput($sformatf("sat%0d.flush_count_w2", k), 32'(s_flush_count), (k < 3) ? k : 3);
            checkOutput($sformatf("sat%0d.flush_count_w16", k), 32'(flush_count), k);
            checkOutput($sformatf("sat%0d.stall_count_w2", k), 32'(s_stall_count), 32'd0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
